// File: rtl/adc_muestreo_serial_pkg.sv
// ---------------------------------------------------------------------------
// adc_muestreo_serial_pkg : audio-path constants and ADC read-frame states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package adc_muestreo_serial_pkg;

  localparam int CLK_HZ      = 100_000_000;
  localparam int FS_DIV_HALF = 1134;
  localparam int FRAME_BITS  = 16;
  localparam int DATA_W      = 12;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_SETUP = SETUP,
    ST_SHIFT = SHIFT,
    ST_DONE  = DONE
  } state_e;

endpackage

`default_nettype wire

// File: rtl/adc_muestreo_serial_gen_sclk_tick.sv
// ---------------------------------------------------------------------------
// gen_sclk_tick : enable-gated counter, one-cycle tick every SCLK_DIV cycles
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gen_sclk_tick #(
  parameter int SCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam logic [3:0] C_LAST = 4'(SCLK_DIV - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = 4'd0;
    if (en && (cnt_q != C_LAST)) cnt_d = cnt_q + 4'd1;
  end

  assign tick = en && (cnt_q == C_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/adc_muestreo_serial.sv
// ---------------------------------------------------------------------------
// adc_muestreo_serial : one SPI read of a 12-bit ADC per rising s_clk edge
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adc_muestreo_serial
  import adc_muestreo_serial_pkg::*;
#(
  parameter int SCLK_DIV   = 4,
  parameter int FRAME_BITS = adc_muestreo_serial_pkg::FRAME_BITS,
  parameter int DATA_W     = adc_muestreo_serial_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_clk,
  input  logic              sdata,
  output logic              cs_n,
  output logic              sclk,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              overrun
);

  localparam logic [4:0] C_LAST_BIT = 5'(FRAME_BITS - 1);

  state_e              state_q, state_d;
  logic                s_q_q, s_q_d;
  logic                cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;

  logic                start;
  logic                tick_en;
  logic                tick;

  assign start   = s_clk & ~s_q_q;
  assign tick_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT);

  gen_sclk_tick #(
    .SCLK_DIV (SCLK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    s_q_d     = s_clk;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;

    case (state_q)
      ST_IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        if (start) begin
          state_d   = ST_SETUP;
          cs_n_d    = 1'b0;
          shift_d   = '0;
          bit_cnt_d = 5'd0;
        end
      end
      ST_SETUP: begin
        if (tick) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          // Capture on the low-to-high sclk transition; the leading bits fall off the top.
          if (!sclk_q) begin
            shift_d   = {shift_q[DATA_W-2:0], sdata};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == C_LAST_BIT) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        cs_n_d   = 1'b1;
        sclk_d   = 1'b1;
        sample_d = shift_q;
        valid_d  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start && (state_q != ST_IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      s_q_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      shift_q   <= '0;
      bit_cnt_q <= 5'd0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q_q     <= s_q_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign cs_n         = cs_n_q;
  assign sclk         = sclk_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_muestreo_serial.sv
// ---------------------------------------------------------------------------
// tb_adc_muestreo_serial : directed bench with a frame-timing model of the ADC read
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_adc_muestreo_serial;
  import adc_muestreo_serial_pkg::*;

  localparam int NONE = -1000000;
  localparam int INF  = 1 << 30;
  localparam int LAT  = 4 * (2 * 16 + 1) + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_clk = 1'b0;
  logic        sdata = 1'b0;
  wire         cs_n;
  wire         sclk;
  wire  [11:0] sample;
  wire         sample_valid;
  wire         overrun;

  adc_muestreo_serial dut (
    .clk          (clk),
    .reset        (reset),
    .s_clk        (s_clk),
    .sdata        (sdata),
    .cs_n         (cs_n),
    .sclk         (sclk),
    .sample       (sample),
    .sample_valid (sample_valid),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          fr_c = NONE;
  logic [15:0] fr_w = 16'h0;
  int          ovr_at = INF;
  logic [11:0] sample_exp = 12'h0;
  int          valid_cyc[$];
  logic [11:0] valid_val[$];

  // ADC: word latched when selected, next bit presented on every sclk fall
  logic [15:0] adc_word = 16'h0;
  logic [15:0] adc_sh = 16'h0;
  always @(negedge cs_n) adc_sh = adc_word;
  always @(negedge sclk) begin
    if (!cs_n) begin
      sdata  = adc_sh[15];
      adc_sh = {adc_sh[14:0], 1'b0};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Frame timeline relative to the cycle r in which s_clk was raised (d = cyc - r)
  always @(posedge clk) begin : compare
    int   d;
    logic e_cs, e_sclk, e_valid, e_ovr;
    cyc = cyc + 1;
    #1;
    d       = cyc - fr_c;
    e_cs    = !(d >= 1 && d <= LAT - 1);
    e_sclk  = !(d >= 9 && d <= LAT - 2 && ((d - 9) % 8) < 4);
    e_valid = (d == LAT);
    e_ovr   = (cyc >= ovr_at);
    if (e_valid) sample_exp = fr_w[11:0];
    chk("cs_n",         32'(cs_n),         32'(e_cs));
    chk("sclk",         32'(sclk),         32'(e_sclk));
    chk("sample_valid", 32'(sample_valid), 32'(e_valid));
    chk("sample",       32'(sample),       32'(sample_exp));
    chk("overrun",      32'(overrun),      32'(e_ovr));
    if (sample_valid === 1'b1) begin
      valid_cyc.push_back(cyc);
      valid_val.push_back(sample);
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic s_rise(input logic [15:0] w);
    int r;
    r = cyc;
    if (fr_c != NONE && r >= fr_c + 1 && r <= fr_c + LAT - 1) begin
      if (ovr_at == INF) ovr_at = r + 1;
    end else begin
      fr_c     = r;
      fr_w     = w;
      adc_word = w;
    end
    s_clk = 1'b1;
  endtask

  task automatic pulse_frame(input logic [15:0] w, input int tail);
    s_rise(w);
    wait_neg(10);
    s_clk = 1'b0;
    wait_neg(tail);
  endtask

  logic [15:0] div_words [5];
  logic [11:0] div_exp   [5];
  int          t0;

  initial begin
    div_words = '{16'h0FFF, 16'h0000, 16'h0800, 16'h07FF, 16'h0001};
    div_exp   = '{12'hFFF, 12'h000, 12'h800, 12'h7FF, 12'h001};

    // reset and idle
    wait_neg(10);
    reset = 1'b1;
    wait_neg(1);
    chk("rst_cs_n",    32'(cs_n),         32'd1);
    chk("rst_sclk",    32'(sclk),         32'd1);
    chk("rst_sample",  32'(sample),       32'd0);
    chk("rst_valid",   32'(sample_valid), 32'd0);
    chk("rst_overrun", 32'(overrun),      32'd0);
    wait_neg(3000);
    chk("idle_no_valid", 32'(valid_cyc.size()), 32'd0);

    // single frame latency and data
    t0 = cyc;
    s_rise(16'h0A5A);
    wait_neg(1);
    chk("cs_n_low_t0p1", 32'(cs_n), 32'd0);
    wait_neg(19);
    s_clk = 1'b0;
    wait_neg(LAT - 20);
    chk("t0p134_valid",  32'(sample_valid), 32'd1);
    chk("t0p134_sample", 32'(sample),       32'hA5A);
    chk("t0p134_cs_n",   32'(cs_n),         32'd1);
    wait_neg(1);
    chk("valid_one_cycle", 32'(sample_valid), 32'd0);
    chk("sample_holds",    32'(sample),       32'hA5A);
    wait_neg(50);

    // divider-paced frames
    valid_cyc.delete();
    valid_val.delete();
    for (int i = 0; i < 5; i++) begin
      s_rise(div_words[i]);
      wait_neg(FS_DIV_HALF);
      s_clk = 1'b0;
      wait_neg(FS_DIV_HALF);
    end
    chk("div_valid_count", 32'(valid_cyc.size()), 32'd5);
    if (valid_cyc.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("div_sample", 32'(valid_val[i]), 32'(div_exp[i]));
        if (i > 0) chk("div_spacing", 32'(valid_cyc[i] - valid_cyc[i-1]), 32'd2268);
      end
    end
    chk("div_overrun", 32'(overrun), 32'd0);

    // overrun: second rising edge 50 cycles into a frame
    valid_cyc.delete();
    valid_val.delete();
    s_rise(16'h0C3C);
    wait_neg(10);
    s_clk = 1'b0;
    wait_neg(40);
    s_rise(16'hFFFF);
    wait_neg(10);
    s_clk = 1'b0;
    wait_neg(200);
    chk("ovr_one_frame", 32'(valid_cyc.size()), 32'd1);
    if (valid_cyc.size() == 1) chk("ovr_sample", 32'(valid_val[0]), 32'hC3C);
    chk("ovr_set", 32'(overrun), 32'd1);
    wait_neg(500);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // asynchronous reset mid-shift, while sclk is low
    valid_cyc.delete();
    valid_val.delete();
    pulse_frame(16'h0321, 58);
    reset      = 1'b0;
    fr_c       = NONE;
    ovr_at     = INF;
    sample_exp = 12'h0;
    #1;
    chk("async_cs_n",    32'(cs_n),    32'd1);
    chk("async_sclk",    32'(sclk),    32'd1);
    chk("async_overrun", 32'(overrun), 32'd0);
    wait_neg(5);
    reset = 1'b1;
    wait_neg(300);
    chk("abort_no_valid", 32'(valid_cyc.size()), 32'd0);
    pulse_frame(16'h0A5A, 200);
    chk("post_rst_count", 32'(valid_cyc.size()), 32'd1);
    if (valid_cyc.size() == 1) chk("post_rst_sample", 32'(valid_val[0]), 32'hA5A);

    // nonzero leading bits are discarded
    valid_cyc.delete();
    valid_val.delete();
    t0 = cyc;
    pulse_frame(16'hF123, 200);
    chk("lead_count", 32'(valid_cyc.size()), 32'd1);
    if (valid_cyc.size() == 1) begin
      chk("lead_sample",  32'(valid_val[0]), 32'h123);
      chk("lead_latency", 32'(valid_cyc[0] - t0), 32'(LAT));
    end
    chk("final_overrun", 32'(overrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
